// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side handshake (req/we/addr/wdata -> gnt/done/rdata/busy)
// and the single-port memory bus (mem_addr/mem_wdata/mem_rd/mem_wr <- mem_rdata)
// seen by mem_port_arbiter.
//
// Modports:
//   master : requesters + memory (drive req/we/addr*/wdata*/mem_rdata[/lock])
//   slave  : the arbiter (drives gnt/done/rdata/busy and the mem_* strobes)
//
// Optional: `define ARB_LOCK_EN adds the 2-bit lock signal (bus locking).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_LOCK_EN
   logic [1:0]        lock;
`endif

   modport master (
`ifdef ARB_LOCK_EN
      output lock,
`endif
      output req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  gnt, done, rdata, busy, mem_addr, mem_wdata, mem_rd, mem_wr
   );

   modport slave (
`ifdef ARB_LOCK_EN
      input  lock,
`endif
      input  req, we, addr0, addr1, wdata0, wdata1, mem_rdata,
      output gnt, done, rdata, busy, mem_addr, mem_wdata, mem_rd, mem_wr
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between requester 0 (sequence controller) and
// requester 1 (I/O / debug loader). Round-robin arbitration, one memory access
// per grant, read data returned after a fixed MEM_LAT latency.
//
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : mem_port_arbiter_if.slave
//          req[1:0], we[1:0], addr0/1, wdata0/1 in; gnt/done one-hot pulses,
//          rdata, busy out; mem_addr/mem_wdata/mem_rd/mem_wr out, mem_rdata in
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (1..7, fits the 3-bit latency counter)
//
// Optional: `define ARB_LOCK_EN enables bus locking through bus.lock. A winner
// holding lock in its DONE cycle keeps exclusive access until a DONE without it.
//
// Timing (gnt in cycle t):
//   write : mem_wr at t+1, done at t+2
//   read  : mem_rd at t+1, rdata captured at t+1+MEM_LAT, done at t+2+MEM_LAT
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   state_t            state_nx;

   logic              ptr;        // preferred requester when both ask
   logic              win;        // requester owning the current transaction
   logic              we_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [2:0]        cnt;
   logic [DATA_W-1:0] rdata_q;

   logic [1:0]        elig;
   logic              pick_valid;
   logic              pick;
   logic              locked;
`ifdef ARB_LOCK_EN
   logic              owner;
`endif

   // ---------------------------------------------------------------------------
   // Arbitration: who would win if we are in IDLE this cycle
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default at the top of a combinational block so
      // no path leaves it unassigned, which would otherwise infer a latch.
      elig = bus.req;
`ifdef ARB_LOCK_EN
      // While locked only the owner is visible; the other requester starves.
      if (locked) elig = bus.req & (owner ? 2'b10 : 2'b01);
`endif
      pick_valid = (state == IDLE) && (elig != 2'b00) && !rst;
      pick       = (elig == 2'b11) ? ptr : elig[1];
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pick_valid) state_nx = ISSUE;
         ISSUE:   state_nx = we_l ? DONE : WAIT;
         // cnt == 1 is the cycle in which the counter reaches zero
         WAIT:    if (cnt == 3'd1) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.gnt    = 2'b00;
      bus.done   = 2'b00;
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
      bus.busy   = (state != IDLE);
      case (state)
         IDLE:  if (pick_valid) bus.gnt[pick] = 1'b1;
         ISSUE: begin
            bus.mem_wr = we_l;
            bus.mem_rd = !we_l;
         end
         // A transaction cut short by reset never reports completion.
         DONE:  if (!rst) bus.done[win] = 1'b1;
         default: ;
      endcase
   end

   // Address and write data come straight from the latch, so they stay
   // stable for the whole ISSUE/WAIT window.
   assign bus.mem_addr  = addr_l;
   assign bus.mem_wdata = wdata_l;
   assign bus.rdata     = rdata_q;

   // ---------------------------------------------------------------------------
   // Datapath: request latch, pointer, latency counter, read-data capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are reset too, because rdata and the
         // memory address/data outputs must read zero after reset.
         ptr     <= 1'b0;
         win     <= 1'b0;
         we_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         if (pick_valid) begin
            win     <= pick;
            we_l    <= bus.we[pick];
            addr_l  <= pick ? bus.addr1  : bus.addr0;
            wdata_l <= pick ? bus.wdata1 : bus.wdata0;
            if (!locked) ptr <= !pick;
         end
         if (state == ISSUE)     cnt <= 3'(MEM_LAT);
         else if (state == WAIT) cnt <= cnt - 3'd1;
         if (state == WAIT && cnt == 3'd1) rdata_q <= bus.mem_rdata;
      end
   end

`ifdef ARB_LOCK_EN
   // Lock ownership is decided by the winner's lock bit in its DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked <= 1'b0;
         owner  <= 1'b0;
      end else if (state == DONE) begin
         locked <= bus.lock[win];
         owner  <= win;
      end
   end
`else
   assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Randomised requesters drive the arbiter; a transaction-level reference model
// predicts grant, strobe and completion events (cycle + value) into queues, and
// a monitor compares every DUT event against the queue heads. A behavioural
// memory returns read data MEM_LAT cycles after mem_rd. Mid-read resets are
// injected to check that in-flight transactions are abandoned.
// Works with and without `define ARB_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 8;
   localparam int MEM_LAT    = 3;
   localparam int RUN_CYCLES = 4000;
   localparam int MAX_CYCLES = 20000;
`ifdef ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } ev_t;
   typedef ev_t evq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // scoreboard state
   evq_t gq;
   evq_t sq;
   evq_t dq;
   bit   exp_busy      = 1'b0;
   int   rst_chk_cycle = -1;
   bit   started       = 1'b0;
   bit   sim_end       = 1'b0;
   int   n_checks      = 0;
   int   n_pass        = 0;

   logic [DATA_W-1:0] tb_mem  [2**ADDR_W];
   logic [DATA_W-1:0] ref_mem [2**ADDR_W];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
   endtask

   task automatic missing(input string name, input int at);
      n_checks++;
      $display("FAIL %s: event due at cycle %0d not seen (now %0d)", name, at, cyc);
   endtask

   function automatic evq_t keep_before(evq_t q, int lim);
      evq_t r;
      foreach (q[k]) if (q[k].cyc < lim) r.push_back(q[k]);
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural memory: data read in cycle c is presented during cycle c+MEM_LAT,
   // otherwise mem_rdata carries junk.
   // ---------------------------------------------------------------------------
   initial begin : memory
      logic [DATA_W-1:0] ring_d [8];
      int                ring_c [8];
      int                c;
      for (int k = 0; k < 8; k++) ring_c[k] = -1;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         c = cyc;
         if (bus.mem_wr === 1'b1) tb_mem[bus.mem_addr] = bus.mem_wdata;
         if (bus.mem_rd === 1'b1) begin
            ring_d[(c + MEM_LAT) % 8] = tb_mem[bus.mem_addr];
            ring_c[(c + MEM_LAT) % 8] = c + MEM_LAT;
         end
         bus.mem_rdata = (ring_c[c % 8] == c) ? ring_d[c % 8] : DATA_W'($urandom);
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: compares each DUT event against the head of its expected queue
   // ---------------------------------------------------------------------------
   initial begin : monitor
      int  c;
      ev_t e;
      wait (started);
      while (!sim_end) begin
         @(negedge clk);
         #1;
         c = cyc;
         if (rst !== 1'b0) continue;
         check("busy", 64'(bus.busy), 64'(exp_busy));
         if (c == rst_chk_cycle) begin
            check("reset_rdata", 64'(bus.rdata), 64'(0));
            check("reset_outputs",
                  64'({bus.done, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}), 64'(0));
         end

         while (gq.size() != 0 && gq[0].cyc < c) begin
            missing("gnt", gq[0].cyc);
            void'(gq.pop_front());
         end
         if (bus.gnt !== 2'b00) begin
            if (gq.size() == 0) check("gnt_unexpected", 64'(bus.gnt), 64'(0));
            else begin
               e = gq.pop_front();
               check("gnt", {32'(c), 32'(bus.gnt)}, {32'(e.cyc), e.val});
            end
         end

         while (sq.size() != 0 && sq[0].cyc < c) begin
            missing("mem_strobe", sq[0].cyc);
            void'(sq.pop_front());
         end
         if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
            if (sq.size() == 0) check("strobe_unexpected", 64'({bus.mem_wr, bus.mem_rd}), 64'(0));
            else begin
               e = sq.pop_front();
               check("mem_strobe",
                     {32'(c), 32'({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_wdata})},
                     {32'(e.cyc), e.val});
            end
         end

         while (dq.size() != 0 && dq[0].cyc < c) begin
            missing("done", dq[0].cyc);
            void'(dq.pop_front());
         end
         if (bus.done !== 2'b00) begin
            if (dq.size() == 0) check("done_unexpected", 64'(bus.done), 64'(0));
            else begin
               e = dq.pop_front();
               check("done_rdata", {32'(c), 32'({bus.done, bus.rdata})}, {32'(e.cyc), e.val});
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus + transaction-level reference model
   // ---------------------------------------------------------------------------
   initial begin : stim
      int                c, c0, free_at, cur_g, cur_done, done_c;
      int                n_tx, n_rst, next_rst_tx;
      bit                ptr, locked, owner, cur_read, cur_w, w, do_rst;
      bit                pend [2];
      int                ready_at [2];
      bit                t_we [2];
      bit                t_lock [2];
      logic [ADDR_W-1:0] t_addr [2];
      logic [DATA_W-1:0] t_wdata [2];
      logic [DATA_W-1:0] last_rd;
      logic [1:0]        elig, we_v, lock_v;

      for (int a = 0; a < 2**ADDR_W; a++) begin
         ref_mem[a] = DATA_W'($urandom);
         tb_mem[a]  = ref_mem[a];
      end
      bus.req    = 2'b00;
      bus.we     = 2'b00;
      bus.addr0  = '0;
      bus.addr1  = '0;
      bus.wdata0 = '0;
      bus.wdata1 = '0;
`ifdef ARB_LOCK_EN
      bus.lock   = 2'b00;
`endif
      rst = 1'b1;
      repeat (4) @(negedge clk);

      c0            = cyc;
      rst           = 1'b0;
      free_at       = c0;
      cur_g         = -10;
      cur_done      = -10;
      cur_read      = 1'b0;
      cur_w         = 1'b0;
      ptr           = 1'b0;
      locked        = 1'b0;
      owner         = 1'b0;
      last_rd       = '0;
      n_tx          = 0;
      n_rst         = 0;
      next_rst_tx   = 15;
      rst_chk_cycle = c0 + 1;
      for (int i = 0; i < 2; i++) begin
         pend[i]     = 1'b0;
         ready_at[i] = c0 + 1;
         t_we[i]     = 1'b0;
         t_lock[i]   = 1'b0;
         t_addr[i]   = '0;
         t_wdata[i]  = '0;
      end
      started = 1'b1;

      while (1) begin
         c = cyc;
         if (c - c0 > MAX_CYCLES) begin
            missing("run_bound", c0 + MAX_CYCLES);
            break;
         end
         if (c >= c0 + RUN_CYCLES && !pend[0] && !pend[1] && c > cur_done + 2) break;

         // Reset in the middle of a read's WAIT phase.
         do_rst = (n_rst < 2) && (n_tx >= next_rst_tx) && cur_read && (c == cur_g + 3);
         rst = do_rst;
         if (do_rst) begin
            gq = keep_before(gq, c);
            sq = keep_before(sq, c);
            dq = keep_before(dq, c);
            ready_at[cur_w] = c;
            free_at         = c + 1;
            ptr             = 1'b0;
            locked          = 1'b0;
            last_rd         = '0;
            cur_done        = c;
            rst_chk_cycle   = c + 1;
            n_rst++;
            next_rst_tx     = n_tx + 30;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (!pend[i] && c > ready_at[i] && c < c0 + RUN_CYCLES &&
                   $urandom_range(99) < 55) begin
                  pend[i]    = 1'b1;
                  t_we[i]    = 1'($urandom_range(1));
                  t_addr[i]  = ADDR_W'($urandom);
                  t_wdata[i] = DATA_W'($urandom);
                  t_lock[i]  = LOCK_EN && ($urandom_range(99) < 60);
               end
            end
         end

         // Drive requester pins; idle requesters present junk on their buses.
         for (int i = 0; i < 2; i++) begin
            we_v[i]   = pend[i] ? t_we[i] : 1'($urandom);
            lock_v[i] = (pend[i] || c <= ready_at[i]) ? t_lock[i] : 1'($urandom);
         end
         bus.req    = {pend[1], pend[0]};
         bus.we     = we_v;
         bus.addr0  = pend[0] ? t_addr[0]  : ADDR_W'($urandom);
         bus.addr1  = pend[1] ? t_addr[1]  : ADDR_W'($urandom);
         bus.wdata0 = pend[0] ? t_wdata[0] : DATA_W'($urandom);
         bus.wdata1 = pend[1] ? t_wdata[1] : DATA_W'($urandom);
`ifdef ARB_LOCK_EN
         bus.lock   = lock_v;
`endif

         // Arbitration decision and predicted transaction timeline.
         if (!do_rst && c >= free_at) begin
            elig = {pend[1], pend[0]};
            if (locked) elig = elig & (owner ? 2'b10 : 2'b01);
            if (elig != 2'b00) begin
               w = (elig == 2'b11) ? ptr : elig[1];
               if (!locked) ptr = !w;
               locked = t_lock[w];
               owner  = w;
               gq.push_back('{c, 32'(w ? 2'b10 : 2'b01)});
               sq.push_back('{c + 1, 32'({t_we[w], !t_we[w], t_addr[w], t_wdata[w]})});
               if (t_we[w]) begin
                  ref_mem[t_addr[w]] = t_wdata[w];
                  done_c = c + 2;
               end else begin
                  last_rd = ref_mem[t_addr[w]];
                  done_c  = c + 2 + MEM_LAT;
               end
               dq.push_back('{done_c, 32'({(w ? 2'b10 : 2'b01), last_rd})});
               free_at     = done_c + 1;
               cur_g       = c;
               cur_done    = done_c;
               cur_read    = !t_we[w];
               cur_w       = w;
               pend[w]     = 1'b0;
               ready_at[w] = done_c;
               n_tx++;
            end
         end

         exp_busy = (c > cur_g) && (c <= cur_done);
         @(negedge clk);
      end

      sim_end = 1'b1;
      repeat (2) @(negedge clk);
      check("gnt_leftover",    64'(gq.size()), 64'(0));
      check("strobe_leftover", 64'(sq.size()), 64'(0));
      check("done_leftover",   64'(dq.size()), 64'(0));
      check("resets_injected", 64'(n_rst),     64'(2));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
